// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared EX/MEM pipeline types, widths and control-bit indices
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_REG_W  = 5;
  localparam int WB_CTL_W    = 2;
  localparam int M_CTL_W     = 3;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;

  // One EX result as carried into MEM; field order fixes the packed layout.
  typedef struct packed {
    logic [WB_CTL_W-1:0]    wb_ctl;
    logic [M_CTL_W-1:0]     m_ctl;
    logic [PIPE_DATA_W-1:0] add_result;
    logic                   zero;
    logic [PIPE_DATA_W-1:0] alu_result;
    logic [PIPE_DATA_W-1:0] rdata2;
    logic [PIPE_REG_W-1:0]  dest_reg;
  } ex_mem_payload_t;

  localparam int PAYLOAD_W = $bits(ex_mem_payload_t);

endpackage

// File: rtl/skid_buf.sv
// rtl/skid_buf.sv - two-entry valid/ready skid buffer with flush
module skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_main_valid;
  logic             r_skid_valid;
  logic             w_accept;
  logic             w_deliver;

  // in_ready is a register output: it only depends on whether the skid slot is occupied.
  assign in_ready  = !r_skid_valid;
  assign out_valid = r_main_valid;
  assign out_data  = r_main;
  assign w_accept  = in_valid & !r_skid_valid;
  assign w_deliver = r_main_valid & out_ready;

  // Main/skid occupancy and data movement; flush beats both accept and deliver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_deliver) begin
      // With the skid full, in_ready is low, so no accept can collide with the refill.
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main <= in_data;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (r_main_valid) begin
        r_skid       <= in_data;
        r_skid_valid <= 1'b1;
      end else begin
        r_main       <= in_data;
        r_main_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_mem_skid.sv
// rtl/ex_mem_skid.sv - EX/MEM pipeline register with skid buffer; EX_MEM_STALL_CNT_EN adds stall_cnt
module ex_mem_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int REG_W  = PIPE_REG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WB_CTL_W-1:0] in_wb_ctl,
  input  logic [M_CTL_W-1:0]  in_m_ctl,
  input  logic [DATA_W-1:0]   in_add_result,
  input  logic                in_zero,
  input  logic [DATA_W-1:0]   in_alu_result,
  input  logic [DATA_W-1:0]   in_rdata2,
  input  logic [REG_W-1:0]    in_dest_reg,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WB_CTL_W-1:0] out_wb_ctl,
  output logic [M_CTL_W-1:0]  out_m_ctl,
  output logic [DATA_W-1:0]   out_add_result,
  output logic                out_zero,
  output logic [DATA_W-1:0]   out_alu_result,
  output logic [DATA_W-1:0]   out_rdata2,
  output logic [REG_W-1:0]    out_dest_reg,
  output logic                out_pcsrc
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  ex_mem_payload_t w_in;
  ex_mem_payload_t w_out;
  logic            w_out_valid;

  // The payload struct is sized from the package; DATA_W/REG_W default to the same widths.
  assign w_in.wb_ctl     = in_wb_ctl;
  assign w_in.m_ctl      = in_m_ctl;
  assign w_in.add_result = in_add_result;
  assign w_in.zero       = in_zero;
  assign w_in.alu_result = in_alu_result;
  assign w_in.rdata2     = in_rdata2;
  assign w_in.dest_reg   = in_dest_reg;

  skid_buf #(
    .WIDTH (PAYLOAD_W)
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in),
    .flush     (flush),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .out_data  (w_out)
  );

  assign out_valid      = w_out_valid;
  assign out_wb_ctl     = w_out.wb_ctl;
  assign out_m_ctl      = w_out.m_ctl;
  assign out_add_result = w_out.add_result;
  assign out_zero       = w_out.zero;
  assign out_alu_result = w_out.alu_result;
  assign out_rdata2     = w_out.rdata2;
  assign out_dest_reg   = w_out.dest_reg;

  // Branch taken only for a live head entry with the branch bit set and a zero compare.
  assign out_pcsrc = w_out_valid & w_out.m_ctl[M_BRANCH] & w_out.zero;

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count cycles where MEM holds off a valid head; wraps naturally and survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !out_ready) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
